// File: rtl/multiplier_divider.sv
// rtl/multiplier_divider.sv - sequential restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor
module multiplier_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendl,
  input  logic [WIDTH-1:0] dividendh,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotientl,
  output logic [WIDTH-1:0] quotienth,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             divzero
);

  localparam int CW = $clog2(2 * WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quotl_q, quotl_d;
  logic [WIDTH-1:0]   quoth_q, quoth_d;
  logic [WIDTH-1:0]   remo_q, remo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;

  // The partial remainder is always < divisor between steps, so WIDTH bits of
  // storage suffice; the extra bit only exists inside the shifted trial value.
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   r_next;
  logic [2*WIDTH-1:0] dvd_next;

  always_comb begin
    shifted  = {rem_q, dvd_q[2*WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    ge       = ~diff[WIDTH];
    r_next   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_next = {dvd_q[2*WIDTH-2:0], ge};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quotl_d   = quotl_q;
    quoth_d   = quoth_q;
    remo_d    = remo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotl_d   = '1;
            quoth_d   = '1;
            remo_d    = dividendl;
            divzero_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            dvd_d     = {dividendh, dividendl};
            dvs_d     = divisor;
            rem_d     = '0;
            cnt_d     = CW'(2 * WIDTH);
            divzero_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        // Quotient bits fill the dividend register from the bottom as it drains.
        dvd_d = dvd_next;
        rem_d = r_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quotl_d = dvd_next[WIDTH-1:0];
          quoth_d = dvd_next[2*WIDTH-1:WIDTH];
          remo_d  = r_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quotl_q   <= '0;
      quoth_q   <= '0;
      remo_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quotl_q   <= quotl_d;
      quoth_q   <= quoth_d;
      remo_q    <= remo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign quotientl = quotl_q;
  assign quotienth = quoth_q;
  assign remainder = remo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign divzero   = divzero_q;

endmodule

// File: tb/tb_multiplier_divider.sv
// tb/tb_multiplier_divider.sv - scoreboard bench for multiplier_divider against a plain-arithmetic model
module tb_multiplier_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividendl, dividendh, divisor;
  logic [31:0] quotientl, quotienth, remainder;
  logic        busy, done, divzero;

  multiplier_divider #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dividendl (dividendl),
    .dividendh (dividendh),
    .divisor   (divisor),
    .quotientl (quotientl),
    .quotienth (quotienth),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .divzero   (divzero)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] ql;
    logic [31:0] qh;
    logic [31:0] rm;
    logic        dz;
    int          c;
    logic [63:0] dvd;
    logic [31:0] dv;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain 64-bit division; divide-by-zero returns all ones and dividendl.
  task automatic push_exp(input logic [31:0] dh, input logic [31:0] dl, input logic [31:0] dv, input int c);
    exp_t        e;
    logic [63:0] n;
    logic [63:0] q;
    logic [63:0] r;
    n = {dh, dl};
    e.dvd = n;
    e.dv  = dv;
    if (dv == 32'd0) begin
      e.ql = 32'hFFFF_FFFF;
      e.qh = 32'hFFFF_FFFF;
      e.rm = dl;
      e.dz = 1'b1;
      e.c  = c;
    end else begin
      q = n / {32'd0, dv};
      r = n % {32'd0, dv};
      e.ql = q[31:0];
      e.qh = q[63:32];
      e.rm = r[31:0];
      e.dz = 1'b0;
      e.c  = c + 64;
    end
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {63'd0, done}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("quotientl", {32'd0, quotientl}, {32'd0, e.ql});
          check("quotienth", {32'd0, quotienth}, {32'd0, e.qh});
          check("remainder", {32'd0, remainder}, {32'd0, e.rm});
          check("divzero", {63'd0, divzero}, {63'd0, e.dz});
          check("done_cycle", 64'(cyc), 64'(e.c));
          if (!e.dz) begin
            check("q_times_d_plus_r", {quotienth, quotientl} * {32'd0, e.dv} + {32'd0, remainder}, e.dvd);
            check("rem_lt_div", {63'd0, remainder < e.dv}, 64'd1);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] dh, input logic [31:0] dl, input logic [31:0] dv);
    dividendh = dh;
    dividendl = dl;
    divisor   = dv;
    start     = 1'b1;
    @(posedge clock);
    #1;
    push_exp(dh, dl, dv, cyc);
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt);
    bit seen;
    seen     = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) busy_cnt++;
    end
    if (!seen) check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          b;
    int          ndone;
    int          mode;
    logic [31:0] a, bb, dh, dl, dv;
    logic [63:0] p;

    reset = 1'b1; start = 1'b0;
    dividendl = '0; dividendh = '0; divisor = '0;
    @(negedge clock); @(negedge clock);
    check("rst_quotientl", {32'd0, quotientl}, 64'd0);
    check("rst_quotienth", {32'd0, quotienth}, 64'd0);
    check("rst_remainder", {32'd0, remainder}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_divzero", {63'd0, divzero}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    issue(32'd0, 32'd300, 32'd30);
    wait_done(b);
    check("s1_busy_cycles", 64'(b), 64'd64);
    check("s1_busy_low_at_done", {63'd0, busy}, 64'd0);

    issue(32'd1, 32'd0, 32'd2);           wait_done(b);
    issue(32'd0, 32'd31, 32'd7);          wait_done(b);
    issue('1, '1, '1);                    wait_done(b);
    issue('1, '1, 32'd1);                 wait_done(b);

    issue(32'd0, 32'd123, 32'd0);
    wait_done(b);
    check("s4_busy_never", 64'(b), 64'd0);
    issue(32'd0, 32'd300, 32'd30);        wait_done(b);

    // A start pulse mid-operation must not disturb it.
    issue(32'd0, 32'd300, 32'd30);
    repeat (9) @(negedge clock);
    dividendl = 32'd999; divisor = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(b);

    // Start held through the done cycle: the second op is accepted right away.
    dividendh = 32'd0; dividendl = 32'd300; divisor = 32'd30; start = 1'b1;
    @(posedge clock);
    #1;
    push_exp(32'd0, 32'd300, 32'd30, cyc);
    dividendl = 32'd77; divisor = 32'd5;
    wait_done(b);
    @(posedge clock);
    #1;
    push_exp(32'd0, 32'd77, 32'd5, cyc);
    start = 1'b0;
    check("s5b_busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done(b);

    // Reset mid-operation: everything clears at once and no done follows.
    issue(32'd0, 32'd300, 32'd30);
    repeat (20) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("s5c_quotientl", {32'd0, quotientl}, 64'd0);
    check("s5c_quotienth", {32'd0, quotienth}, 64'd0);
    check("s5c_remainder", {32'd0, remainder}, 64'd0);
    check("s5c_busy", {63'd0, busy}, 64'd0);
    check("s5c_done", {63'd0, done}, 64'd0);
    check("s5c_divzero", {63'd0, divzero}, 64'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done === 1'b1) ndone++;
    end
    check("s5c_no_done_after_reset", 64'(ndone), 64'd0);
    issue(32'd0, 32'd300, 32'd30);        wait_done(b);

    for (int k = 0; k < 400; k++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          a  = $urandom;
          bb = $urandom;
          if (bb == 32'd0) bb = 32'd1;
          p  = {32'd0, a} * {32'd0, bb};
          dh = p[63:32]; dl = p[31:0]; dv = bb;
        end
        1: begin
          dh = $urandom; dl = $urandom; dv = $urandom;
        end
        2: begin
          dh = $urandom; dl = $urandom; dv = $urandom_range(1, 15);
        end
        default: begin
          dh = $urandom; dl = $urandom;
          dv = ($urandom_range(0, 9) == 0) ? 32'd0 : ($urandom | 32'h8000_0000);
        end
      endcase
      issue(dh, dl, dv);
      wait_done(b);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
